// File: rtl/module_rca_accumulator.sv
// Multi-operand accumulator built around a single ripple-carry adder.
// A burst of operands is summed into a RCAWIDE-bit accumulator; each RCA
// carry-out bumps a COUNTW-bit extension so {carry_cnt, sum} is exact.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; no operand or result handshake
// ACCUM | accepting operands, remaining counts down to the last one
// DONE  | full-precision result held on the result port
module module_rca_accumulator #(
  parameter int RCAWIDE = 8,
  parameter int COUNTW  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [COUNTW-1:0]  num_ops_i,
  input  logic               op_valid_i,
  input  logic [RCAWIDE-1:0] op_data_i,
  output logic               op_ready_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [RCAWIDE-1:0] sum_o,
  output logic [COUNTW-1:0]  carry_cnt_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RCAWIDE-1:0]  acc_q, acc_d;
  logic [COUNTW-1:0]   carry_cnt_q, carry_cnt_d;
  logic [COUNTW-1:0]   remaining_q, remaining_d;

  logic [RCAWIDE-1:0]  rca_sum;
  logic                rca_carry;
  logic                xfer;

  // The only wide adder on the accumulator path.
  module_ripple_carry_adder #(
    .RCAWIDE (RCAWIDE)
  ) u_rca (
    .a_i     (acc_q),
    .b_i     (op_data_i),
    .carry_i (1'b0),
    .sum_o   (rca_sum),
    .carry_o (rca_carry)
  );

  assign xfer = (state_q == ACCUM) && op_valid_i;

  // Next-state and datapath update; remaining is a down-counter whose
  // terminal value 1 marks the last operand of the burst.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d       = '0;
          carry_cnt_d = '0;
          remaining_d = num_ops_i;
          state_d     = (num_ops_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d       = rca_sum;
          // Narrow increment by 0 or 1; cannot wrap because at most
          // num_ops-1 carries occur in a burst.
          carry_cnt_d = carry_cnt_q + {{(COUNTW-1){1'b0}}, rca_carry};
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(COUNTW-1){1'b0}}, 1'b1}) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_cnt_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs come only from registers and state decode.
  assign op_ready_o  = (state_q == ACCUM);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = acc_q;
  assign carry_cnt_o = carry_cnt_q;

endmodule

// Plain ripple-carry adder: RCAWIDE chained full adders.
module module_ripple_carry_adder #(
  parameter int RCAWIDE = 8
) (
  input  logic [RCAWIDE-1:0] a_i,
  input  logic [RCAWIDE-1:0] b_i,
  input  logic               carry_i,
  output logic [RCAWIDE-1:0] sum_o,
  output logic               carry_o
);

  logic [RCAWIDE:0] c;

  assign c[0] = carry_i;

  // One full-adder stage per bit, carry rippling upward.
  for (genvar i = 0; i < RCAWIDE; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[RCAWIDE];

endmodule

// File: tb/tb_module_rca_accumulator.sv
// Directed bench for module_rca_accumulator with hand-computed results.
module tb_module_rca_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] num_ops;
  logic       op_valid;
  logic [7:0] op_data;
  logic       op_ready;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] sum;
  logic [3:0] carry_cnt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  module_rca_accumulator #(
    .RCAWIDE (8),
    .COUNTW  (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .num_ops_i   (num_ops),
    .op_valid_i  (op_valid),
    .op_data_i   (op_data),
    .op_ready_o  (op_ready),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .sum_o       (sum),
    .carry_cnt_o (carry_cnt),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, op_ready},  32'd0);
  endtask

  task automatic check_result(input string tag, input int exp_sum, input int exp_cnt);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_sum"},   {24'd0, sum},       exp_sum);
    check({tag, "_cnt"},   {28'd0, carry_cnt}, exp_cnt);
  endtask

  initial begin
    logic [7:0] bp_ops [4];
    bp_ops = '{8'd200, 8'd100, 8'd50, 8'd7};

    rst_n = 1'b0; start = 1'b0; num_ops = '0; op_valid = 1'b0;
    op_data = '0; res_ready = 1'b0;
    repeat (2) step();
    check_idle("rst");
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cnt", {28'd0, carry_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic sum 10+20+30, no stalls.
    start = 1'b1; num_ops = 4'd3;
    step();
    start = 1'b0;
    check("basic_ready", {31'd0, op_ready}, 32'd1);
    check("basic_busy",  {31'd0, busy},     32'd1);
    op_valid = 1'b1; op_data = 8'd10; step();
    op_data = 8'd20; step();
    check("basic_notyet", {31'd0, res_valid}, 32'd0);
    op_data = 8'd30; step();
    op_valid = 1'b0;
    check_result("basic", 60, 0);
    check("basic_done_ready", {31'd0, op_ready}, 32'd0);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check_idle("basic_ack");

    // Carries: 15 x 255 = 3825.
    start = 1'b1; num_ops = 4'd15; step();
    start = 1'b0;
    op_valid = 1'b1; op_data = 8'd255;
    repeat (14) step();
    check("carry_notyet", {31'd0, res_valid}, 32'd0);
    step();
    op_valid = 1'b0;
    check_result("carry", 241, 14);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check_idle("carry_ack");

    // Back-pressure on both sides: gapped operands, stalled result.
    start = 1'b1; num_ops = 4'd4; step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op_data = bp_ops[i]; step();
      op_valid = 1'b0;
      if (i < 3) begin
        check("bp_gap_ready", {31'd0, op_ready}, 32'd1);
        step();
      end
    end
    check_result("bp", 101, 1);
    for (int i = 0; i < 5; i++) begin
      op_valid = (i == 2); op_data = 8'd99;
      step();
      check_result("bp_stall", 101, 1);
    end
    op_valid = 1'b0;
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check_idle("bp_ack");

    // Zero-length burst, with op_valid asserted in IDLE.
    start = 1'b1; num_ops = 4'd0; op_valid = 1'b1; op_data = 8'd5;
    step();
    start = 1'b0;
    check_result("zero", 0, 0);
    op_data = 8'd77; step();
    check_result("zero_hold", 0, 0);
    op_valid = 1'b0;
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check_idle("zero_ack");

    // op_valid in IDLE alone must not start anything.
    op_valid = 1'b1; op_data = 8'd9; step();
    op_valid = 1'b0;
    check_idle("idle_valid");

    // start_i during ACCUM is ignored: burst {4,6} still sums to 10.
    start = 1'b1; num_ops = 4'd2; step();
    start = 1'b1; num_ops = 4'd5; op_valid = 1'b1; op_data = 8'd4; step();
    start = 1'b0; op_data = 8'd6; step();
    op_valid = 1'b0;
    check_result("ign_start", 10, 0);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check_idle("ign_ack");

    // Back-to-back bursts {1,2} then {255,1}.
    start = 1'b1; num_ops = 4'd2; step();
    start = 1'b0;
    op_valid = 1'b1; op_data = 8'd1; step();
    op_data = 8'd2; step();
    op_valid = 1'b0;
    check_result("b2b1", 3, 0);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    start = 1'b1; num_ops = 4'd2;
    check_idle("b2b_gap");
    step();
    start = 1'b0;
    check("b2b2_ready", {31'd0, op_ready}, 32'd1);
    check("b2b2_clr", {24'd0, sum}, 32'd0);
    op_valid = 1'b1; op_data = 8'd255; step();
    op_data = 8'd1; step();
    op_valid = 1'b0;
    check_result("b2b2", 0, 1);
    res_ready = 1'b1; step();
    check("b2b2_one_cycle", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;

    // Asynchronous reset after 2 of 5 operands.
    start = 1'b1; num_ops = 4'd5; step();
    start = 1'b0;
    op_valid = 1'b1; op_data = 8'd100; step();
    op_data = 8'd200; step();
    op_valid = 1'b0;
    check("pre_rst_sum", {24'd0, sum}, 32'd44);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_sum", {24'd0, sum}, 32'd0);
    check("async_rst_cnt", {28'd0, carry_cnt}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    op_valid = 1'b1; op_data = 8'd3;
    repeat (4) begin
      step();
      check_idle("post_rst");
    end
    op_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
